// File: rtl/ahb_decoder_mux.sv
`default_nettype none
// ============================================================================
// Module      : ahb_decoder_mux
// Description : AHB-Lite address decoder and slave-to-master response mux.
//               Decodes the address phase into one-hot slave selects, records
//               the data-phase owner and steers read data, response and ready
//               from that owner back to the master. Unmapped NONSEQ/SEQ
//               transfers are answered by an internal default slave.
// Config      : `define AHB_DEC_ERR_RESP_EN -> the default slave gives a
//               two-cycle ERROR response and counts decode errors in
//               o_err_cnt. Undefined -> unmapped transfers complete with OKAY,
//               zero wait, and o_err_cnt is tied to zero.
// Ports       : HCLK / HRESETn      bus clock, asynchronous active-low reset
//               i_HADDR, i_HTRANS   master address phase
//               o_HSEL              one-hot address-phase slave selects
//               i_s_HRDATA/HRESP/HREADYOUT  flattened per-slave responses
//               o_HRDATA/HRESP/HREADY       muxed response to master (HREADY
//                                           also feeds every slave HREADY)
//               o_err_cnt           saturating decode-error count
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_decoder_mux #(
  parameter int                         N_SLV    = 4,
  parameter int                         ADDR_W   = 32,
  parameter int                         DATA_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0]    SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLV*ADDR_W-1:0]    SLV_MASK = {4{32'hF000_0000}}
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [ADDR_W-1:0]         i_HADDR,
  input  logic [1:0]                i_HTRANS,
  output logic [N_SLV-1:0]          o_HSEL,
  input  logic [N_SLV*DATA_W-1:0]   i_s_HRDATA,
  input  logic [N_SLV*2-1:0]        i_s_HRESP,
  input  logic [N_SLV-1:0]          i_s_HREADYOUT,
  output logic [DATA_W-1:0]         o_HRDATA,
  output logic [1:0]                o_HRESP,
  output logic                      o_HREADY,
  output logic [7:0]                o_err_cnt
);

  // Slave index is held at a fixed width wide enough for the 16-slave maximum.
  localparam int         c_IDX_W      = 4;
  localparam logic [1:0] c_RESP_OKAY  = 2'b00;
  localparam logic [1:0] c_RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SLV  = 2'd1,
    OWN_DEF  = 2'd2
  } own_t;

  logic               w_dec_hit;
  logic [c_IDX_W-1:0] w_dec_idx;
  logic [N_SLV-1:0]   w_hsel;
  logic [DATA_W-1:0]  w_hrdata;
  logic [1:0]         w_hresp;
  logic               w_hready;
  logic               w_unused_htrans0;

  own_t               r_own;
  logic [c_IDX_W-1:0] r_own_idx;

  // Only the NONSEQ/SEQ distinction (bit 1) matters to this block.
  assign w_unused_htrans0 = i_HTRANS[0];

  // --------------------------------------------------------------------------
  // Address decode. Scanning from the top index down lets the lowest matching
  // slot overwrite higher ones, giving lowest-index priority on overlap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((i_HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = c_IDX_W'(i);
      end
    end
  end

  for (genvar g = 0; g < N_SLV; g++) begin : g_hsel
    assign w_hsel[g] = w_dec_hit && (w_dec_idx == c_IDX_W'(g));
  end

  assign o_HSEL = w_hsel;

  // --------------------------------------------------------------------------
  // Data-phase owner: captures the decode whenever the bus is ready, so a
  // wait state from any owner freezes it until its data phase completes.
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_own     <= OWN_NONE;
      r_own_idx <= '0;
    end else if (w_hready) begin
      if (w_dec_hit) begin
        r_own     <= OWN_SLV;
        r_own_idx <= w_dec_idx;
      end else if (i_HTRANS[1]) begin
        r_own     <= OWN_DEF;
        r_own_idx <= '0;
      end else begin
        r_own     <= OWN_NONE;
        r_own_idx <= '0;
      end
    end
  end

`ifdef AHB_DEC_ERR_RESP_EN
  // --------------------------------------------------------------------------
  // Default slave: two-cycle ERROR response for unmapped active transfers.
  // The entry condition is identical to the owner register loading OWN_DEF,
  // so DS_ERR1/DS_ERR2 always coincide with a default-slave data phase.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_t;

  ds_t        r_ds;
  logic [7:0] r_err_cnt;
  logic       w_err_start;

  assign w_err_start = w_hready && !w_dec_hit && i_HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ds      <= DS_IDLE;
      r_err_cnt <= 8'h00;
    end else begin
      case (r_ds)
        DS_ERR1: r_ds <= DS_ERR2;
        default: begin
          // DS_IDLE and DS_ERR2 both sample a fresh address phase.
          if (w_err_start) begin
            r_ds <= DS_ERR1;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end else begin
            r_ds <= DS_IDLE;
          end
        end
      endcase
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Response mux. NONE (and DEFAULT when error responses are disabled) reads
  // as a zero-wait OKAY with zero data.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hrdata = '0;
    w_hresp  = c_RESP_OKAY;
    w_hready = 1'b1;
    case (r_own)
      OWN_SLV: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (r_own_idx == c_IDX_W'(i)) begin
            w_hrdata = i_s_HRDATA[i*DATA_W +: DATA_W];
            w_hresp  = i_s_HRESP[i*2 +: 2];
            w_hready = i_s_HREADYOUT[i];
          end
        end
      end
`ifdef AHB_DEC_ERR_RESP_EN
      OWN_DEF: begin
        w_hresp  = c_RESP_ERROR;
        w_hready = (r_ds != DS_ERR1);
      end
`endif
      default: ;
    endcase
  end

  assign o_HRDATA = w_hrdata;
  assign o_HRESP  = w_hresp;
  assign o_HREADY = w_hready;

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_decoder_mux
// Description : Directed self-checking bench for ahb_decoder_mux. Expected
//               data-phase outputs are queued with each address phase and
//               popped on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_decoder_mux;

  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_NS   = 2'b10;

  typedef struct {
    string       tag;
    logic [3:0]  hsel;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        ready;
  } exp_t;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [31:0]   i_HADDR;
  logic [1:0]    i_HTRANS;
  logic [3:0]    o_HSEL;
  logic [127:0]  i_s_HRDATA;
  logic [7:0]    i_s_HRESP;
  logic [3:0]    i_s_HREADYOUT;
  logic [31:0]   o_HRDATA;
  logic [1:0]    o_HRESP;
  logic          o_HREADY;
  logic [7:0]    o_err_cnt;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_cnt      = 0;

  always #5 HCLK = ~HCLK;

  ahb_decoder_mux dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .i_HADDR       (i_HADDR),
    .i_HTRANS      (i_HTRANS),
    .o_HSEL        (o_HSEL),
    .i_s_HRDATA    (i_s_HRDATA),
    .i_s_HRESP     (i_s_HRESP),
    .i_s_HREADYOUT (i_s_HREADYOUT),
    .o_HRDATA      (o_HRDATA),
    .o_HRESP       (o_HRESP),
    .o_HREADY      (o_HREADY),
    .o_err_cnt     (o_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compare this cycle's outputs against the oldest queued expectation,
  // then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge HCLK);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hsel"},  {28'd0, o_HSEL},   {28'd0, e.hsel});
      chk({e.tag, "_rdata"}, o_HRDATA,          e.rdata);
      chk({e.tag, "_resp"},  {30'd0, o_HRESP},  {30'd0, e.resp});
      chk({e.tag, "_ready"}, {31'd0, o_HREADY}, {31'd0, e.ready});
    end
    @(posedge HCLK);
    #1;
  endtask

  // Drive one address phase and queue what must be seen during this cycle.
  task automatic cyc(input string tag, input logic [31:0] a, input logic [1:0] t,
                     input logic [3:0] xs, input logic [31:0] xd,
                     input logic [1:0] xr, input logic xy);
    exp_t e;
    i_HADDR  = a;
    i_HTRANS = t;
    e.tag = tag; e.hsel = xs; e.rdata = xd; e.resp = xr; e.ready = xy;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    i_HADDR       = 32'h5000_0000;
    i_HTRANS      = c_IDLE;
    i_s_HRDATA    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0A0A};
    i_s_HRESP     = 8'b01_00_00_00;
    i_s_HREADYOUT = 4'hF;

    // Reset state
    @(negedge HCLK);
    chk("rst_ready", {31'd0, o_HREADY}, 32'd1);
    chk("rst_resp",  {30'd0, o_HRESP},  32'd0);
    chk("rst_rdata", o_HRDATA,          32'd0);
    chk("rst_errc",  {24'd0, o_err_cnt}, 32'd0);
    chk("rst_hsel",  {28'd0, o_HSEL},   32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Basic decode and read mux
    cyc("t35a",     32'h1000_0004, c_NS,   4'b0010, 32'h0,         2'b00, 1'b1);
    cyc("t35b",     32'h0000_0010, c_NS,   4'b0001, 32'hDEAD_BEEF, 2'b00, 1'b1);
    cyc("t_slot3",  32'h3FFF_FFFC, c_NS,   4'b1000, 32'h0000_0A0A, 2'b00, 1'b1);
    cyc("t_s3dp",   32'h5000_0000, c_IDLE, 4'b0000, 32'h3333_3333, 2'b01, 1'b1);
    cyc("t_none",   32'h5000_0000, c_IDLE, 4'b0000, 32'h0,         2'b00, 1'b1);
    cyc("t_mapidl", 32'h2000_0000, c_IDLE, 4'b0100, 32'h0,         2'b00, 1'b1);

    // Slave wait states hold the owner
    cyc("t37a",     32'h2000_0000, c_NS,   4'b0100, 32'h2222_2222, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      i_s_HREADYOUT[2] = 1'b0;
      cyc("t37w",   32'h1000_0000, c_NS,   4'b0010, 32'h2222_2222, 2'b00, 1'b0);
    end
    i_s_HREADYOUT[2] = 1'b1;
    cyc("t37d",     32'h1000_0000, c_NS,   4'b0010, 32'h2222_2222, 2'b00, 1'b1);
    cyc("t37n",     32'h5000_0000, c_IDLE, 4'b0000, 32'hDEAD_BEEF, 2'b00, 1'b1);

`ifdef AHB_DEC_ERR_RESP_EN
    // Single decode error
    cyc("t36a",  32'h4000_0000, c_NS,   4'b0000, 32'h0, 2'b00, 1'b1);
    cyc("t36e1", 32'h5000_0000, c_IDLE, 4'b0000, 32'h0, 2'b01, 1'b0);
    exp_cnt = 1;
    cyc("t36e2", 32'h5000_0000, c_IDLE, 4'b0000, 32'h0, 2'b01, 1'b1);
    chk("t36_errc", {24'd0, o_err_cnt}, exp_cnt);
    cyc("t36n",  32'h5000_0000, c_IDLE, 4'b0000, 32'h0, 2'b00, 1'b1);

    // Back-to-back errors, then a mapped transfer sampled in DS_ERR2
    cyc("t38a",   32'h4000_0000, c_NS,   4'b0000, 32'h0,         2'b00, 1'b1);
    cyc("t38e1",  32'h4000_0000, c_NS,   4'b0000, 32'h0,         2'b01, 1'b0);
    cyc("t38e2",  32'h4000_0000, c_NS,   4'b0000, 32'h0,         2'b01, 1'b1);
    cyc("t38e1b", 32'h1000_0000, c_NS,   4'b0010, 32'h0,         2'b01, 1'b0);
    cyc("t38e2b", 32'h1000_0000, c_NS,   4'b0010, 32'h0,         2'b01, 1'b1);
    exp_cnt = 3;
    chk("t38_errc", {24'd0, o_err_cnt}, exp_cnt);
    cyc("t38m",   32'h5000_0000, c_IDLE, 4'b0000, 32'hDEAD_BEEF, 2'b00, 1'b1);

    // Counter saturation: 301 error entries from a stream of unmapped NONSEQs
    for (int k = 0; k <= 600; k++) begin
      if (k == 0)
        cyc("t39n",  32'h4000_0000, c_NS, 4'b0000, 32'h0, 2'b00, 1'b1);
      else if (k % 2 == 1)
        cyc("t39e1", 32'h4000_0000, c_NS, 4'b0000, 32'h0, 2'b01, 1'b0);
      else
        cyc("t39e2", 32'h4000_0000, c_NS, 4'b0000, 32'h0, 2'b01, 1'b1);
      if (k % 2 == 0 && exp_cnt < 255) exp_cnt++;
    end
    chk("t39_sat",  {24'd0, o_err_cnt}, exp_cnt);
    chk("t39_err1", {31'd0, o_HREADY},  32'd0);
    // Asynchronous reset in DS_ERR1
    i_HADDR = 32'h1000_0000;
    HRESETn = 1'b0;
    #1;
    chk("t39r_ready", {31'd0, o_HREADY},  32'd1);
    chk("t39r_resp",  {30'd0, o_HRESP},   32'd0);
    chk("t39r_rdata", o_HRDATA,           32'd0);
    chk("t39r_errc",  {24'd0, o_err_cnt}, 32'd0);
    #1;
    HRESETn = 1'b1;
    cyc("t39post", 32'h1000_0000, c_NS,   4'b0010, 32'h0,         2'b00, 1'b1);
    cyc("t39d",    32'h5000_0000, c_IDLE, 4'b0000, 32'hDEAD_BEEF, 2'b00, 1'b1);
`else
    // Unmapped NONSEQ without error responses: zero-wait OKAY
    cyc("t40a", 32'h4000_0000, c_NS,   4'b0000, 32'h0, 2'b00, 1'b1);
    cyc("t40b", 32'h4000_0000, c_NS,   4'b0000, 32'h0, 2'b00, 1'b1);
    cyc("t40c", 32'h5000_0000, c_IDLE, 4'b0000, 32'h0, 2'b00, 1'b1);
    chk("t40_errc", {24'd0, o_err_cnt}, 32'd0);
`endif

    // Reset during a slave wait aborts it
    cyc("tw_a", 32'h2000_0000, c_NS, 4'b0100, 32'h0, 2'b00, 1'b1);
    i_s_HREADYOUT[2] = 1'b0;
    i_HADDR  = 32'h1000_0000;
    i_HTRANS = c_NS;
    #1;
    chk("tw_wait", {31'd0, o_HREADY}, 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("tw_r_ready", {31'd0, o_HREADY}, 32'd1);
    chk("tw_r_rdata", o_HRDATA,          32'd0);
    #1;
    HRESETn = 1'b1;
    i_s_HREADYOUT[2] = 1'b1;
    cyc("tw_post", 32'h1000_0000, c_NS,   4'b0010, 32'h0,         2'b00, 1'b1);
    cyc("tw_d",    32'h5000_0000, c_IDLE, 4'b0000, 32'hDEAD_BEEF, 2'b00, 1'b1);

    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_decoder_mux.md
AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

Interface
REQ-001 Parameter N_SLV, default 4, number of slave ports (1..16).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, read-data width.
REQ-004 Parameter SLV_BASE, default {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, flattened N_SLV*ADDR_W base addresses; slot i at bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter SLV_MASK, default {4{32'hF000_0000}}, flattened N_SLV*ADDR_W compare masks.
REQ-006 Clocking and reset: reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-007 HCLK  in  1  bus clock.
REQ-008 HRESETn  in  1  async active-low reset.
REQ-009 i_HADDR  in  ADDR_W  master address-phase address.
REQ-010 i_HTRANS  in  2  master transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-011 o_HSEL  out  N_SLV  one-hot address-phase slave selects.
REQ-012 i_s_HRDATA  in  N_SLV*DATA_W  flattened slave read data.
REQ-013 i_s_HRESP  in  N_SLV*2  flattened slave responses.
REQ-014 i_s_HREADYOUT  in  N_SLV  slave ready outputs.
REQ-015 o_HRDATA  out  DATA_W  muxed read data to master.
REQ-016 o_HRESP  out  2  muxed response (OKAY 00, ERROR 01).
REQ-017 o_HREADY  out  1  muxed ready, driven to master and all slave HREADY inputs.
REQ-018 o_err_cnt  out  8  saturating count of decode errors.

Function
REQ-019 Slot i matches when (i_HADDR & MASK_i) == BASE_i; on overlap the lowest index wins; o_HSEL is combinational, at most one bit set, independent of i_HTRANS.
REQ-020 Unmapped = no slot matches; o_HSEL all zero.
REQ-021 A data-phase owner register (slave index, DEFAULT, or NONE) SHALL load the address-phase decode on every HCLK rising edge with o_HREADY=1 and hold while o_HREADY=0.
REQ-022 Owner slave i: o_HRDATA/o_HRESP/o_HREADY = slot i inputs, zero added latency (combinational mux).
REQ-023 Owner NONE or DEFAULT: o_HRDATA = 0.
REQ-024 Owner NONE (after reset, or unmapped IDLE/BUSY sampled): o_HREADY=1, o_HRESP=OKAY.
REQ-025 Default-slave FSM states DS_IDLE, DS_ERR1, DS_ERR2.
REQ-026 DS_IDLE -> DS_ERR1 on edge with o_HREADY=1, unmapped, i_HTRANS[1]=1.
REQ-027 DS_ERR1: o_HREADY=0, o_HRESP=ERROR; always -> DS_ERR2 next edge.
REQ-028 DS_ERR2: o_HREADY=1, o_HRESP=ERROR; -> DS_ERR1 if new unmapped NONSEQ/SEQ sampled this edge, else DS_IDLE (mapped transfer sampled in DS_ERR2 proceeds normally).
REQ-029 o_err_cnt increments by 1 on each DS_IDLE/DS_ERR2 -> DS_ERR1 transition, saturates at 8'hFF, never wraps.
REQ-030 Slave wait states (i_s_HREADYOUT=0) hold owner and o_HSEL-registered state; no owner change mid-data-phase.

Reset
REQ-031 HRESETn low asynchronously forces owner=NONE, FSM=DS_IDLE, o_err_cnt=0; outputs become o_HREADY=1, o_HRESP=OKAY, o_HRDATA=0.
REQ-032 Reset asserted mid-transfer (including DS_ERR1 or a slave wait) aborts it; first post-reset edge samples a fresh address phase.

Configuration
REQ-033 Macro AHB_DEC_ERR_RESP_EN defined: default-slave FSM and o_err_cnt present per REQ-025..029.
REQ-034 Macro undefined: unmapped NONSEQ/SEQ get OKAY, o_HREADY=1, o_HRDATA=0 zero-wait; FSM and counter removed; o_err_cnt tied 8'h00.

Verification
REQ-035 NONSEQ read 0x1000_0004, slot1 HRDATA=0xDEAD_BEEF -> o_HSEL=4'b0010, next cycle o_HRDATA=0xDEAD_BEEF, o_HRESP=00.
REQ-036 NONSEQ 0x4000_0000 (with _EN) -> o_HSEL=0; next cycle HREADY=0/HRESP=01, then HREADY=1/HRESP=01; o_err_cnt=1.
REQ-037 Slot2 HREADYOUT=0 for 3 cycles at 0x2000_0000 -> o_HREADY=0 for 3 cycles, owner stays slot2, then data returned.
REQ-038 Back-to-back NONSEQ 0x4000_0000 presented in DS_ERR2 -> ERR1,ERR2,ERR1,ERR2 sequence; o_err_cnt=2.
REQ-039 300 unmapped NONSEQ transfers -> o_err_cnt=8'hFF; HRESETn pulse during DS_ERR1 -> o_HREADY=1, o_HRESP=00, o_err_cnt=0 immediately.
REQ-040 Without _EN, NONSEQ 0x4000_0000 -> o_HREADY=1, o_HRESP=00, o_HRDATA=0 next cycle; o_err_cnt=0.
